// File: rtl/montgomery_modexp_ctrl_if.sv
// Bus between the modexp sequencer and the shared montgomery_mul datapath.
// The master drives operands and the start pulse; the slave returns results.
interface montgomery_modexp_ctrl_if #(
  parameter int NBITS = 2048,
  localparam int MW = $clog2(NBITS) + 3
);
  logic             mm_enable_p;
  logic [NBITS-1:0] mm_a;
  logic [NBITS-1:0] mm_b;
  logic [NBITS-1:0] mm_m;
  logic [MW-1:0]    mm_m_size;
  logic [NBITS-1:0] mm_y;
  logic             mm_done_irq_p;

  modport master (
    output mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
    input  mm_y, mm_done_irq_p
  );

  modport slave (
    input  mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
    output mm_y, mm_done_irq_p
  );
endinterface

// File: rtl/montgomery_modexp_ctrl.sv
// Modular exponentiation sequencer: to-Montgomery, left-to-right
// square-and-multiply, from-Montgomery, all through one external multiplier.
module montgomery_modexp_ctrl #(
  parameter int NBITS = 2048,
  parameter int EBITS = 2048,
  localparam int EW = $clog2(EBITS) + 1,
  localparam int IW = $clog2(EBITS),
  localparam int MW = $clog2(NBITS) + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [EBITS-1:0] e,
  input  logic [EW-1:0]    e_size,
  input  logic [NBITS-1:0] m,
  input  logic [MW-1:0]    m_size,
  input  logic [NBITS-1:0] r2,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p,
  montgomery_modexp_ctrl_if.master mm
);

  typedef enum logic [2:0] {
    S_IDLE, S_TO_A, S_TO_ONE, S_SQR,
    S_MUL, S_NEXT, S_FROM, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] r2_q, r2_d;
  logic [EBITS-1:0] e_q, e_d;
  logic [EW-1:0]    es_q, es_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] abar_q, abar_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mm_en_q, mm_en_d;
  logic [NBITS-1:0] mm_a_q, mm_a_d;
  logic [NBITS-1:0] mm_b_q, mm_b_d;
  logic [NBITS-1:0] mm_m_q, mm_m_d;
  logic [MW-1:0]    mm_ms_q, mm_ms_d;
  logic             mm_done;
  logic [EW-1:0]    es_clamp;

  always_comb begin
    state_d  = state_q;
    r2_d     = r2_q;
    e_d      = e_q;
    es_d     = es_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    abar_d   = abar_q;
    y_d      = y_q;
    mm_en_d  = 1'b0;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    mm_m_d   = mm_m_q;
    mm_ms_d  = mm_ms_q;
    // a completion in the start cycle cannot belong to this multiply
    mm_done  = mm.mm_done_irq_p && !mm_en_q;
    es_clamp = (e_size > EW'(EBITS)) ? EW'(EBITS) : e_size;

    unique case (state_q)
      S_IDLE: if (enable_p) begin
        r2_d    = r2;
        e_d     = e;
        es_d    = es_clamp;
        mm_m_d  = m;
        mm_ms_d = m_size;
        state_d = S_TO_A;
      end
      S_TO_A: if (mm_done) begin
        abar_d  = mm.mm_y;
        state_d = S_TO_ONE;
      end
      S_TO_ONE: if (mm_done) begin
        acc_d = mm.mm_y;
        if (es_q == '0) begin
          state_d = S_FROM;
        end else begin
          idx_d   = IW'(es_q - EW'(1));
          state_d = S_SQR;
        end
      end
      S_SQR: if (mm_done) begin
        acc_d   = mm.mm_y;
        state_d = e_q[idx_q] ? S_MUL : S_NEXT;
      end
      S_MUL: if (mm_done) begin
        acc_d   = mm.mm_y;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_FROM;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQR;
        end
      end
      S_FROM: if (mm_done) begin
        y_d     = mm.mm_y;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // operands are launched on the cycle an op state is entered
    if (state_d != state_q) begin
      case (state_d)
        S_TO_A: begin
          mm_en_d = 1'b1;
          mm_a_d  = a;
          mm_b_d  = r2;
        end
        S_TO_ONE: begin
          mm_en_d = 1'b1;
          mm_a_d  = NBITS'(1);
          mm_b_d  = r2_q;
        end
        S_SQR: begin
          mm_en_d = 1'b1;
          mm_a_d  = acc_d;
          mm_b_d  = acc_d;
        end
        S_MUL: begin
          mm_en_d = 1'b1;
          mm_a_d  = acc_d;
          mm_b_d  = abar_q;
        end
        S_FROM: begin
          mm_en_d = 1'b1;
          mm_a_d  = acc_d;
          mm_b_d  = NBITS'(1);
        end
        default: mm_en_d = 1'b0;
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r2_q    <= '0;
      e_q     <= '0;
      es_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      abar_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mm_en_q <= 1'b0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      mm_m_q  <= '0;
      mm_ms_q <= '0;
    end else begin
      state_q <= state_d;
      r2_q    <= r2_d;
      e_q     <= e_d;
      es_q    <= es_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      abar_q  <= abar_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mm_en_q <= mm_en_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
      mm_m_q  <= mm_m_d;
      mm_ms_q <= mm_ms_d;
    end
  end

  assign y              = y_q;
  assign busy           = busy_q;
  assign done_irq_p     = done_q;
  assign mm.mm_enable_p = mm_en_q;
  assign mm.mm_a        = mm_a_q;
  assign mm.mm_b        = mm_b_q;
  assign mm.mm_m        = mm_m_q;
  assign mm.mm_m_size   = mm_ms_q;

endmodule
